dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and performs RISC-V byte, halfword and word accesses on an internal word-organised RAM. It returns the load result, or the store acknowledge, after a configurable latency. It sits between the core's `to_dmem`/`fr_dmem` path and the board memory, and replaces the zero-latency combinational data memory.

## Interface
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 32-bit words (4 KiB by default).
- `LATENCY`, default 1: cycles from the request-accept edge to `rsp_valid` asserted. Legal range is 1..15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V funct3 giving width and sign (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010).
- `req_addr` input 32: byte address (the ALU result).
- `req_wdata` input 32: store data, right-aligned (`rs2`).
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: requester takes the response.
- `rsp_rdata` output 32: load result, already extended; 0 for stores and errors.
- `rsp_err` output 1: the request was rejected (misaligned, out of range, or illegal funct3).

## Operation
- FSM states are IDLE, WAIT and RESP. `req_ready` = (state == IDLE) && !rst.
- **IDLE:**
  - On `req_valid && req_ready`, latch the request and evaluate the error.
  - Go to RESP if LATENCY == 1; otherwise go to WAIT with the counter set to LATENCY-2.
- **WAIT:** decrement the counter; go to RESP when the counter is 0.
- **RESP:**
  - Hold `rsp_valid = 1`, `rsp_rdata` and `rsp_err` stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- **Error conditions.** Any one of these sets `rsp_err = 1`:
  - halfword access with `addr[0] = 1`;
  - word access with `addr[1:0] != 0`;
  - `req_addr[31:DEPTH_LOG2+2] != 0` (out of range);
  - load funct3 in {011, 110, 111};
  - store funct3 > 010.
- **Error effects.** An erroneous request writes nothing to RAM and returns `rsp_rdata = 0`.
- **Indexing.** Word index = `req_addr[DEPTH_LOG2+1:2]`. Byte lane = `addr[1:0]`; half lane = `addr[1]`.
- **Stores:**
  - The write commits on the accept edge, with byte enables from width and lane.
  - SB writes `wdata[7:0]` to the selected lane; SH writes `wdata[15:0]` to the selected half.
  - Unselected bytes are unchanged.
- **Loads:**
  - The RAM word is read on the accept edge and the result is registered.
  - LB and LH sign-extend from bit 7 and bit 15 of the selected lane/half. LBU and LHU zero-extend. LW returns the word.
- Exactly one transaction is outstanding; requests never overlap.
- Reset does not clear RAM contents.

## Timing
- **Reset.** While `rst` is high and on the cycle after it: state IDLE, `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_err = 0`, counter 0. `req_ready` is 0 while `rst` is high and 1 from the first cycle after release.
- **Latency.** If accept happens on edge E, `rsp_valid` rises after edge E+LATENCY-1, i.e. it is visible in the LATENCY-th cycle after the accept cycle.
- **Throughput.** With `rsp_ready` tied high, one transaction every LATENCY+1 cycles. `req_ready` returns the cycle after the response handshake.
- **Backpressure.** With `rsp_ready` low, RESP is held indefinitely with outputs frozen. `req_valid` is ignored outside IDLE.
- **Reset mid-transaction.** The pending response is discarded and the FSM returns to IDLE. A store that has already been accepted stays committed.
- **Read after write.** A store followed by a load to the same word always sees the new data, because transactions are serialised.
- **Idle outputs.** After the response handshake, `rsp_rdata` and `rsp_err` hold their last values; only `rsp_valid` is qualifying.

## Test plan
- **Word store and load.** With LATENCY=1, SW 0xDEADBEEF to 0x010, then LW 0x010.
  - Required: `rsp_rdata` = 0xDEADBEEF and `rsp_err` = 0.
  - Required: `rsp_valid` in the cycle after each accept.
  - Required: `req_ready` low during RESP.
- **Byte store and loads.** SW 0x00000000 to 0x020, SB 0x80 to 0x023, then LB 0x023, LBU 0x023 and LW 0x020.
  - Required: 0xFFFFFF80, 0x00000080 and 0x80000000 respectively.
- **Halfword sign handling.** SH 0x8001 to 0x02E, then LH 0x02E and LHU 0x02E.
  - Required: 0xFFFF8001 and 0x00008001.
  - Then LH 0x02F. Required: `rsp_err` = 1 and `rsp_rdata` = 0.
- **Error writes nothing.**
  - SW to 0x032 (misaligned). Required: `rsp_err` = 1.
  - SW to 0x1000 with DEPTH_LOG2=10 (out of range). Required: `rsp_err` = 1.
  - Required: a following LW 0x030 returns its old value unchanged.
  - Load with funct3 = 011. Required: `rsp_err` = 1.
- **Latency and backpressure.** With LATENCY=3, accept LW on edge E.
  - Required: `rsp_valid` rises after edge E+2.
  - Hold `rsp_ready` low for 5 cycles. Required: the data stays stable.
  - Raise `rsp_ready`. Required: `req_ready` goes high the next cycle.
- **Reset mid-operation.** With LATENCY=4, accept SW 0x12345678 to 0x040, then assert `rst` in WAIT.
  - Required: `rsp_valid` never rises, and `req_ready` returns after release.
  - Required: LW 0x040 returns 0x12345678.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RISC-V load/store at a time on an internal
// word-organised RAM, answered after a fixed, parameterised latency.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            count;
    logic [31:0]           mem [DEPTH];
    logic [31:0]           pend_rdata;
    logic                  pend_err;

    logic                  accept;
    logic [DEPTH_LOG2-1:0] index;
    logic [1:0]            lane;
    logic [31:0]           word;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic                  legal;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  err;
    logic [3:0]            byte_en;
    logic [31:0]           store_data;
    logic [31:0]           load_data;
    logic [31:0]           result;

    assign req_ready    = (state == IDLE) && !rst;
    assign accept       = req_valid && req_ready;
    assign index        = req_addr[DEPTH_LOG2+1:2];
    assign lane         = req_addr[1:0];
    assign word         = mem[index];
    assign sel_byte     = 8'(word >> {lane, 3'b000});
    assign sel_half     = lane[1] ? word[31:16] : word[15:0];
    assign out_of_range = (req_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
    assign err          = !legal || misaligned || out_of_range;
    assign result       = (req_we || err) ? 32'd0 : load_data;

    // Decode width/sign, lane enables and the extended load value of the current request.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case leaves one unassigned and infers a latch.
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        store_data = 32'd0;
        load_data  = 32'd0;
        if (req_we) begin
            legal = (req_funct3 <= 3'b010);
        end else begin
            legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
        end
        case (req_funct3[1:0])
            SZ_BYTE: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{req_wdata[7:0]}};
                load_data  = {{24{sel_byte[7] & ~req_funct3[2]}}, sel_byte};
            end
            SZ_HALF: begin
                misaligned = lane[0];
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{req_wdata[15:0]}};
                load_data  = {{16{sel_half[15] & ~req_funct3[2]}}, sel_half};
            end
            SZ_WORD: begin
                misaligned = (lane != 2'b00);
                byte_en    = 4'b1111;
                store_data = req_wdata;
                load_data  = word;
            end
            default: ;
        endcase
    end

    // NOTE: the RAM array has no reset, so its contents survive rst and it maps onto a plain memory macro.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[index][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    // The result is captured at accept and only copied to the outputs when RESP is entered,
    // so rsp_rdata/rsp_err keep their last values while idle or waiting.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            count      <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
            pend_rdata <= 32'd0;
            pend_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pend_rdata <= result;
                        pend_err   <= err;
                        if (LATENCY <= 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= result;
                            rsp_err   <= err;
                        end else begin
                            state <= WAIT;
                            count <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_rdata;
                        rsp_err   <= pend_err;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 3, 4) checked against a
// byte-addressed reference memory model, with directed and randomized scenarios.
module tb_dmem_responder;
    localparam int NDUT = 3;
    localparam int LAT [NDUT] = '{1, 3, 4};

    logic        clk = 1'b0;
    logic        rst        [NDUT];
    logic        req_valid  [NDUT];
    logic        req_ready  [NDUT];
    logic        req_we     [NDUT];
    logic [2:0]  req_funct3 [NDUT];
    logic [31:0] req_addr   [NDUT];
    logic [31:0] req_wdata  [NDUT];
    logic        rsp_valid  [NDUT];
    logic        rsp_ready  [NDUT];
    logic [31:0] rsp_rdata  [NDUT];
    logic        rsp_err    [NDUT];

    int n_cmp  = 0;
    int n_fail = 0;

    bit [7:0] ref_mem [NDUT][4096];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT[g])) u_dut (
            .clk(clk), .rst(rst[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
            .req_funct3(req_funct3[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
        );
    end

    // Reference: a 4 KiB byte array accessed with plain address arithmetic.
    function automatic void ref_access(input int d, input bit we, input bit [2:0] f3,
                                       input bit [31:0] addr, input bit [31:0] wdata,
                                       output bit [31:0] rdata, output bit err);
        int  size;
        bit  legal;
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || (addr % size != 0) || (addr >= 32'd4096);
        rdata = 32'd0;
        if (err) return;
        for (int i = 0; i < size; i++) begin
            if (we) ref_mem[d][addr + i] = wdata[8*i +: 8];
            else    rdata[8*i +: 8] = ref_mem[d][addr + i];
        end
        if (!we && !f3[2] && size < 4 && rdata[8*size-1])
            rdata = rdata | ~((32'd1 << (8*size)) - 32'd1);
    endfunction

    // One full transaction; rsp_ready is held low for 'hold' extra cycles once rsp_valid is seen.
    task automatic txn(input int d, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wdata, input int hold,
                       output bit [31:0] rdata, output bit err, output int lat,
                       output bit rdy_in_resp, output bit stable, output bit rdy_after,
                       output bit [31:0] exp_rdata, output bit exp_err);
        int n;
        n = 0;
        rdata = 32'd0; err = 1'b0; rdy_in_resp = 1'b1; stable = 1'b0; rdy_after = 1'b0;
        @(negedge clk);
        while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
        req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
        req_addr[d] = addr; req_wdata[d] = wdata;
        ref_access(d, we, f3, addr, wdata, exp_rdata, exp_err);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin @(negedge clk); lat++; end
        if (!rsp_valid[d]) begin lat = -1; return; end
        rdata = rsp_rdata[d]; err = rsp_err[d]; rdy_in_resp = req_ready[d]; stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!rsp_valid[d] || rsp_rdata[d] !== rdata || rsp_err[d] !== err) stable = 1'b0;
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        rdy_after = req_ready[d] && !rsp_valid[d];
    endtask

    bit [31:0] rd, erd;
    bit        er, eer, rir, stb, raf;
    int        lat;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++; if (req_ready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready d%0d got %b want 0", d, req_ready[d]); end
            n_cmp++; if (rsp_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid d%0d got %b want 0", d, rsp_valid[d]); end
            n_cmp++; if (rsp_rdata[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata d%0d got %h want 0", d, rsp_rdata[d]); end
            n_cmp++; if (rsp_err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err d%0d got %b want 0", d, rsp_err[d]); end
        end
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++; if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) begin
                n_fail++; $display("FAIL post_reset d%0d ready/valid got %b/%b want 1/0", d, req_ready[d], rsp_valid[d]);
            end
        end
    endtask

    // Known contents for words 0..31 and 1008..1023 of every instance.
    task automatic preload();
        for (int d = 0; d < NDUT; d++) begin
            for (int p = 0; p < 48; p++) begin
                int w;
                w = (p < 32) ? p : 976 + p;
                txn(d, 1'b1, 3'b010, 32'(w * 4), $urandom, 0, rd, er, lat, rir, stb, raf, erd, eer);
                n_cmp++; if (er !== 1'b0 || lat != LAT[d]) begin
                    n_fail++; $display("FAIL preload d%0d w%0d err/lat got %b/%0d want 0/%0d", d, w, er, lat, LAT[d]);
                end
            end
        end
    endtask

    task automatic test_word();
        txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (er !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL sw_rsp err/rdata got %b/%h want 0/0", er, rd); end
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL sw_latency got %0d want 1", lat); end
        txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL lw_data got %h/%b want deadbeef/0", rd, er); end
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL lw_latency got %0d want 1", lat); end
        n_cmp++; if (rir !== 1'b0) begin n_fail++; $display("FAIL ready_in_resp got %b want 0", rir); end
        n_cmp++; if (raf !== 1'b1) begin n_fail++; $display("FAIL ready_after_hs got %b want 1", raf); end
    endtask

    task automatic test_byte();
        txn(0, 1'b1, 3'b010, 32'h20, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        txn(0, 1'b1, 3'b000, 32'h23, 32'h80, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL sb_err got %b want 0", er); end
        txn(0, 1'b0, 3'b000, 32'h23, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb got %h want ffffff80", rd); end
        txn(0, 1'b0, 3'b100, 32'h23, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu got %h want 00000080", rd); end
        txn(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (rd !== 32'h80000000) begin n_fail++; $display("FAIL lw_after_sb got %h want 80000000", rd); end
    endtask

    task automatic test_half();
        txn(0, 1'b1, 3'b001, 32'h2E, 32'h8001, 0, rd, er, lat, rir, stb, raf, erd, eer);
        txn(0, 1'b0, 3'b001, 32'h2E, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh got %h want ffff8001", rd); end
        txn(0, 1'b0, 3'b101, 32'h2E, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (rd !== 32'h00008001) begin n_fail++; $display("FAIL lhu got %h want 00008001", rd); end
        txn(0, 1'b0, 3'b001, 32'h2F, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL lh_misaligned err/rdata got %b/%h want 1/0", er, rd); end
    endtask

    task automatic test_error();
        txn(0, 1'b1, 3'b010, 32'h30, 32'h0BADF00D, 0, rd, er, lat, rir, stb, raf, erd, eer);
        txn(0, 1'b1, 3'b010, 32'h32, 32'h11111111, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL sw_misaligned err/rdata got %b/%h want 1/0", er, rd); end
        txn(0, 1'b1, 3'b010, 32'h1000, 32'h22222222, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL sw_out_of_range err got %b want 1", er); end
        txn(0, 1'b1, 3'b011, 32'h30, 32'h33333333, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL store_f3_011 err got %b want 1", er); end
        txn(0, 1'b0, 3'b010, 32'h30, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin n_fail++; $display("FAIL lw_unchanged got %h/%b want 0badf00d/0", rd, er); end
        txn(0, 1'b0, 3'b010, 32'h0, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL lw_word0_no_alias got %h want %h", rd, erd); end
        txn(0, 1'b0, 3'b011, 32'h30, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL load_f3_011 err/rdata got %b/%h want 1/0", er, rd); end
    endtask

    task automatic test_latency();
        txn(1, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL lat3_store got %0d want 3", lat); end
        txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL lat3_load got %0d want 3", lat); end
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat3_data got %h want cafef00d", rd); end
        n_cmp++; if (stb !== 1'b1) begin n_fail++; $display("FAIL backpressure_stable got %b want 1", stb); end
        n_cmp++; if (rir !== 1'b0) begin n_fail++; $display("FAIL lat3_ready_in_resp got %b want 0", rir); end
        n_cmp++; if (raf !== 1'b1) begin n_fail++; $display("FAIL lat3_ready_after got %b want 1", raf); end
    endtask

    task automatic test_reset_mid();
        bit saw_valid;
        int n;
        n = 0;
        saw_valid = 1'b0;
        @(negedge clk);
        while (!req_ready[2] && n < 50) begin @(negedge clk); n++; end
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_funct3[2] = 3'b010;
        req_addr[2] = 32'h40; req_wdata[2] = 32'h12345678;
        ref_access(2, 1'b1, 3'b010, 32'h40, 32'h12345678, erd, eer);
        @(negedge clk);
        req_valid[2] = 1'b0;
        rst[2] = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready[2] !== 1'b0 || rsp_rdata[2] !== 32'd0 || rsp_err[2] !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_state ready/rdata/err got %b/%h/%b want 0/0/0", req_ready[2], rsp_rdata[2], rsp_err[2]);
        end
        if (rsp_valid[2]) saw_valid = 1'b1;
        @(negedge clk);
        if (rsp_valid[2]) saw_valid = 1'b1;
        rst[2] = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready[2] !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got %b want 1", req_ready[2]); end
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid[2]) saw_valid = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got %b want 0", saw_valid); end
        txn(2, 1'b0, 3'b010, 32'h40, 32'h0, 0, rd, er, lat, rir, stb, raf, erd, eer);
        n_cmp++; if (rd !== 32'h12345678 || er !== 1'b0) begin n_fail++; $display("FAIL store_survives_reset got %h/%b want 12345678/0", rd, er); end
        n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL lat4 got %0d want 4", lat); end
    endtask

    task automatic test_back_to_back(input int d);
        int acc[$];
        int n;
        bit gaps_ok;
        int want;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
        rsp_ready[d] = 1'b1;
        req_valid[d] = 1'b1; req_we[d] = 1'b0; req_funct3[d] = 3'b010; req_addr[d] = 32'h10;
        for (int c = 0; c < 30; c++) begin
            if (req_valid[d] && req_ready[d]) acc.push_back(c);
            @(negedge clk);
        end
        req_valid[d] = 1'b0;
        n = 0;
        while (!req_ready[d] && n < 40) begin @(negedge clk); n++; end
        rsp_ready[d] = 1'b0;
        gaps_ok = 1'b1;
        for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != LAT[d] + 1) gaps_ok = 1'b0;
        want = 29 / (LAT[d] + 1) + 1;
        n_cmp++; if (acc.size() != want) begin n_fail++; $display("FAIL b2b_count d%0d got %0d want %0d", d, acc.size(), want); end
        n_cmp++; if (gaps_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_gap d%0d got irregular want %0d", d, LAT[d] + 1); end
    endtask

    task automatic test_random(input int d);
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        int        r, p, w, off;
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r == 0)      addr = 32'h1000 + 32'($urandom_range(0, 8191));
            else if (r == 1) addr = $urandom | 32'h8000_0000;
            else begin
                p    = $urandom_range(0, 47);
                w    = (p < 32) ? p : 976 + p;
                off  = $urandom_range(0, 1) ? 0 : $urandom_range(0, 3);
                addr = 32'(w * 4 + off);
            end
            txn(d, we, f3, addr, $urandom, $urandom_range(0, 2), rd, er, lat, rir, stb, raf, erd, eer);
            n_cmp++; if (rd !== erd || er !== eer) begin
                n_fail++; $display("FAIL rand d%0d #%0d we%0d f3=%0d a=%h rdata/err got %h/%b want %h/%b", d, i, we, f3, addr, rd, er, erd, eer);
            end
            n_cmp++; if (lat != LAT[d] || stb !== 1'b1 || raf !== 1'b1) begin
                n_fail++; $display("FAIL rand_timing d%0d #%0d lat/stable/ready got %0d/%b/%b want %0d/1/1", d, i, lat, stb, raf, LAT[d]);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'b000;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
        end
        test_reset();
        preload();
        test_word();
        test_byte();
        test_half();
        test_error();
        test_latency();
        test_reset_mid();
        for (int d = 0; d < NDUT; d++) test_back_to_back(d);
        for (int d = 0; d < NDUT; d++) test_random(d);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end
endmodule
